gray_ptr_sync_rx: RTL and testbench

//  Receive-side CDC stage for Gray-coded pointers/counters generated in a remote clock domain.
//  - Synchronises the incoming Gray word through a flop chain.
//  - Converts it to binary and reports per-cycle advance (delta).
//  - Flags multi-step jumps and counts them.

---
 rtl/gray_ptr_sync_rx_pkg.sv | 9 +
 rtl/gray_ptr_sync_rx_if.sv | 33 +++
 rtl/gray_to_bin.sv | 15 +
 rtl/gray_ptr_sync_rx.sv | 112 +++++++++++
 tb/tb_gray_ptr_sync_rx.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/gray_ptr_sync_rx_pkg.sv
// Shared defaults for the Gray pointer receive-side synchroniser.
package gray_ptr_sync_rx_pkg;

    // Default pointer width, synchroniser depth and skip-counter width.
    localparam int DEF_N      = 32;
    localparam int DEF_STAGES = 2;
    localparam int DEF_CNT_W  = 8;

endpackage : gray_ptr_sync_rx_pkg

// File: rtl/gray_ptr_sync_rx_if.sv
// Signal bundle between the remote-domain Gray source and the receive stage.
//
// There is no valid/ready handshake on this bundle: i_G is a free-running
// Gray word that is assumed to change by at most one bit per source step,
// and every output is a plain per-cycle status.  o_skip reports a multi-step
// advance for information only; it never back-pressures the source.
interface gray_ptr_sync_rx_if
    import gray_ptr_sync_rx_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int CNT_W = DEF_CNT_W
);
    logic [N-1:0]     i_G;
    logic             i_clr_cnt;
    logic [N-1:0]     o_G;
    logic [N-1:0]     o_B;
    logic             o_chg;
    logic [N-1:0]     o_delta;
    logic             o_skip;
    logic [CNT_W-1:0] o_skip_cnt;

    // Source side: drives the Gray word and the counter clear.
    modport master (
        output i_G, i_clr_cnt,
        input  o_G, o_B, o_chg, o_delta, o_skip, o_skip_cnt
    );

    // Receive stage side.
    modport slave (
        input  i_G, i_clr_cnt,
        output o_G, o_B, o_chg, o_delta, o_skip, o_skip_cnt
    );
endinterface : gray_ptr_sync_rx_if

// File: rtl/gray_to_bin.sv
// Purely combinational Gray-to-binary converter.
module gray_to_bin #(
    parameter int N = 32
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);
    // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
    always_comb begin
        bin = '0;
        for (int i = 0; i < N; i++) begin
            bin[i] = ^(gray >> i);
        end
    end
endmodule : gray_to_bin

// File: rtl/gray_ptr_sync_rx.sv
// Receive-side CDC stage for a Gray-coded pointer: synchronises the remote
// word, converts it to binary, reports per-cycle advance and counts
// multi-step jumps with a saturating counter.
module gray_ptr_sync_rx
    import gray_ptr_sync_rx_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int STAGES = DEF_STAGES,
    parameter int CNT_W  = DEF_CNT_W
) (
    input logic               i_clk,
    input logic               i_rst,
    gray_ptr_sync_rx_if.slave bus
);
    localparam int               PW         = $clog2(STAGES + 1);
    localparam logic [PW-1:0]    PRIME_DONE = PW'(STAGES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    // sync_q[0] is the metastability-catching flop, sync_q[STAGES-1] the settled one.
    logic [N-1:0]     sync_q [STAGES];
    logic [N-1:0]     sync_out;
    logic [N-1:0]     sync_bin;
    logic [PW-1:0]    prime_q;
    logic [N-1:0]     g_q;
    logic [N-1:0]     b_q;
    logic             chg_q;
    logic [N-1:0]     delta_q;
    logic             skip_q;
    logic [CNT_W-1:0] cnt_q;

    logic             primed;
    logic             chg_next;
    logic [N-1:0]     delta_next;
    logic             skip_next;

    assign sync_out = sync_q[STAGES-1];

    gray_to_bin #(.N(N)) u_gray_to_bin (
        .gray (sync_out),
        .bin  (sync_bin)
    );

    // Plain flop chain; nothing combinational between stages.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= bus.i_G;
            for (int k = 1; k < STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Count edges after reset release until the chain holds real samples.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prime_q <= '0;
        end else if (!primed) begin
            prime_q <= prime_q + 1'b1;
        end
    end

    // Change/advance detection against the previously registered sample.
    // While priming, the chain still holds reset zeros, so no event is reported.
    always_comb begin
        primed     = (prime_q == PRIME_DONE);
        chg_next   = primed && (sync_out != g_q);
        delta_next = chg_next ? (sync_bin - b_q) : '0;
        skip_next  = chg_next && (delta_next > N'(1));
    end

    // Output registers; o_G/o_B load every cycle, including during priming.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            g_q     <= '0;
            b_q     <= '0;
            chg_q   <= 1'b0;
            delta_q <= '0;
            skip_q  <= 1'b0;
        end else begin
            g_q     <= sync_out;
            b_q     <= sync_bin;
            chg_q   <= chg_next;
            delta_q <= delta_next;
            skip_q  <= skip_next;
        end
    end

    // Saturating skip counter; a clear coinciding with a skip leaves one count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (primed) begin
            if (bus.i_clr_cnt) begin
                cnt_q <= skip_next ? CNT_W'(1) : '0;
            end else if (skip_next && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.o_G        = g_q;
    assign bus.o_B        = b_q;
    assign bus.o_chg      = chg_q;
    assign bus.o_delta    = delta_q;
    assign bus.o_skip     = skip_q;
    assign bus.o_skip_cnt = cnt_q;

endmodule : gray_ptr_sync_rx

// File: tb/tb_gray_ptr_sync_rx.sv
// Bench for gray_ptr_sync_rx: directed scenarios followed by random pointer
// traffic, all checked by a scoreboard fed from a sample-delay reference model.
module tb_gray_ptr_sync_rx;
    localparam int N      = 4;
    localparam int STAGES = 2;
    localparam int CNT_W  = 2;
    localparam int OW     = 3 * N + CNT_W + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    gray_ptr_sync_rx_if #(.N(N), .CNT_W(CNT_W)) bus ();

    gray_ptr_sync_rx #(.N(N), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] dut_word;
    int checks = 0;
    int passed = 0;

    assign dut_word = {bus.o_G, bus.o_B, bus.o_chg, bus.o_delta, bus.o_skip, bus.o_skip_cnt};

    // Reference model state: samples seen by the receiver, delayed by STAGES edges.
    logic [N-1:0] samp_q[$];
    int           edges;
    logic [N-1:0] prev_g;
    int           cnt;

    function automatic logic [N-1:0] to_gray(int b);
        return N'(b ^ (b >> 1));
    endfunction

    // Gray bit i flips every binary bit at or below i.
    function automatic int to_bin(logic [N-1:0] g);
        int b = 0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) b = b ^ ((1 << (i + 1)) - 1);
        end
        return b;
    endfunction

    function automatic logic [OW-1:0] pack(logic [N-1:0] g, int b, bit chg, int d, bit skip, int c);
        return {g, N'(b), chg, N'(d), skip, CNT_W'(c)};
    endfunction

    function automatic void model_reset();
        samp_q.delete();
        for (int k = 0; k < STAGES; k++) samp_q.push_back('0);
        edges  = 0;
        prev_g = '0;
        cnt    = 0;
    endfunction

    // One rising edge with input g and clear request clr.
    function automatic void model_edge(logic [N-1:0] g, bit clr);
        logic [N-1:0] og;
        bit primed;
        bit chg;
        bit skip;
        int d;
        samp_q.push_back(g);
        og     = samp_q.pop_front();
        edges  = edges + 1;
        primed = (edges > STAGES);
        chg    = primed && (og != prev_g);
        d      = chg ? ((to_bin(og) - to_bin(prev_g)) & ((1 << N) - 1)) : 0;
        skip   = chg && (d > 1);
        if (primed) begin
            if (clr) cnt = skip ? 1 : 0;
            else if (skip && cnt < (1 << CNT_W) - 1) cnt = cnt + 1;
        end
        prev_g = og;
        exp_q.push_back(pack(og, to_bin(og), chg, d, skip, cnt));
    endfunction

    task automatic check(string name, logic [OW-1:0] act, logic [OW-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got G/B/chg/delta/skip/cnt=%h expected %h", name, act, exp);
    endtask

    // Monitor: outputs are valid every cycle; compare one expectation per edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            check($sformatf("out@%0t", $time), dut_word, exp_q.pop_front());
        end
    end

    // Driver: apply inputs just after a falling edge, predict the next rising edge.
    task automatic drive(logic [N-1:0] g, bit clr);
        bus.i_G       = g;
        bus.i_clr_cnt = clr;
        model_edge(g, clr);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic hold(logic [N-1:0] g, int n);
        for (int k = 0; k < n; k++) drive(g, 1'b0);
    endtask

    // Asynchronous reset between edges; outputs must clear before the next edge.
    task automatic apply_reset(int cycles);
        bus.i_clr_cnt = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("rst_async", dut_word, '0);
        model_reset();
        for (int k = 0; k < cycles; k++) begin
            exp_q.push_back('0);
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    initial begin
        int b;
        int r;
        bus.i_G       = 4'b0110;
        bus.i_clr_cnt = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset held with a non-zero input, then priming.
        apply_reset(3);
        hold(4'b0110, 4);

        // Single steps 0 -> 1 -> 2.
        drive(4'b0000, 1'b0);
        drive(4'b0001, 1'b0);
        drive(4'b0011, 1'b0);
        hold(4'b0011, 3);
        drive(4'b0011, 1'b1);

        // Wrap 15 -> 0.
        hold(4'b1000, 3);
        hold(4'b0000, 3);
        drive(4'b0000, 1'b1);

        // Jumps 1 -> 5 and back, counter saturation.
        hold(4'b0001, 3);
        hold(4'b0111, 3);
        for (int k = 0; k < 4; k++) begin
            hold(4'b0001, 2);
            hold(4'b0111, 2);
        end

        // Clear coinciding with a jump, then clear alone.
        drive(4'b0001, 1'b0);
        drive(4'b0001, 1'b0);
        drive(4'b0001, 1'b1);
        drive(4'b0001, 1'b1);
        hold(4'b0001, 2);

        // Mid-stream reset at B=9, then recovery.
        hold(to_gray(9), 4);
        apply_reset(2);
        hold(to_gray(9), 4);
        drive(to_gray(10), 1'b0);
        drive(to_gray(11), 1'b0);
        hold(to_gray(11), 2);

        // Random pointer traffic: mostly single steps, some holds and jumps.
        b = 11;
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 9);
            if (r < 7) b = (b + 1) % (1 << N);
            else if (r >= 8) b = (b + $urandom_range(2, (1 << N) - 1)) % (1 << N);
            drive(to_gray(b), ($urandom_range(0, 15) == 0));
        end
        hold(to_gray(b), 3);

        #1;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule : tb_gray_ptr_sync_rx
